// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns the raw PS/2 byte stream into whole key events. E0 (extended) and
// F0 (break) prefixes are folded into the event by a small FSM with a resync
// timeout, and completed events queue in a show-ahead FIFO that the consumer
// drains over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   i_rx_ready   one-cycle pulse, i_rx_data holds a new byte
//   i_rx_data    byte from the PS/2 receiver
//   o_ev_valid   FIFO head holds an event
//   i_ev_ready   consumer accepts the head this cycle
//   o_ev_code    scan code of the head event
//   o_ev_ext     head event was E0-prefixed
//   o_ev_break   1 = key release, 0 = key press
//   o_fifo_count number of stored events
//   o_overflow   sticky, an event was dropped because the FIFO was full
//   o_err_pulse  one-cycle pulse after an error byte (00/FF) or a timeout
//   i_clr_ovf    synchronous clear of o_overflow
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rx_ready,
    input  logic [7:0]                    i_rx_data,
    output logic                          o_ev_valid,
    input  logic                          i_ev_ready,
    output logic [7:0]                    o_ev_code,
    output logic                          o_ev_ext,
    output logic                          o_ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_err_pulse,
    input  logic                          i_clr_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t          r_state, w_stateNext;
    logic [TO_W-1:0] r_toCnt, w_toCntNext;
    logic            r_errPulse, w_errNext;
    logic            w_push, w_pushExt, w_pushBrk;

    // FIFO entry layout: {ext, brk, code}
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wrPtr, r_rdPtr, w_rdNext;
    logic [CW-1:0]   r_count, w_countNext;
    logic            r_overflow;
    logic [9:0]      r_head, w_entry, w_headNext;
    logic            w_pop, w_full, w_accept, w_drop;

    logic w_isE0, w_isF0, w_isErr;
    assign w_isE0  = (i_rx_data == 8'hE0);
    assign w_isF0  = (i_rx_data == 8'hF0);
    assign w_isErr = (i_rx_data == 8'h00) || (i_rx_data == 8'hFF);

    // Prefix FSM and timeout. A byte arriving always takes precedence over
    // an expiring timeout, because the timeout branch is only reached
    // when no byte is present.
    always_comb begin
        w_stateNext = r_state;
        w_toCntNext = r_toCnt;
        w_errNext   = 1'b0;
        w_push      = 1'b0;
        w_pushExt   = 1'b0;
        w_pushBrk   = 1'b0;
        if (i_rx_ready) begin
            w_toCntNext = '0;
            if (w_isErr) begin
                w_stateNext = IDLE;
                w_errNext   = 1'b1;
            end else if (w_isE0) begin
                case (r_state)
                    IDLE:    w_stateNext = GOT_E0;
                    GOT_F0:  w_stateNext = GOT_E0F0;
                    default: w_stateNext = r_state;
                endcase
            end else if (w_isF0) begin
                case (r_state)
                    IDLE:    w_stateNext = GOT_F0;
                    GOT_E0:  w_stateNext = GOT_E0F0;
                    default: w_stateNext = r_state;
                endcase
            end else begin
                w_push      = 1'b1;
                w_pushExt   = (r_state == GOT_E0) || (r_state == GOT_E0F0);
                w_pushBrk   = (r_state == GOT_F0) || (r_state == GOT_E0F0);
                w_stateNext = IDLE;
            end
        end else if (r_state != IDLE) begin
            if (r_toCnt == TO_LAST) begin
                w_stateNext = IDLE;
                w_toCntNext = '0;
                w_errNext   = 1'b1;
            end else begin
                w_toCntNext = r_toCnt + TO_W'(1);
            end
        end else begin
            w_toCntNext = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_toCnt    <= '0;
            r_errPulse <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_toCnt    <= w_toCntNext;
            r_errPulse <= w_errNext;
        end
    end

    // FIFO control. When full, a push is only accepted if a pop frees a slot
    // in the same cycle; otherwise the event is dropped.
    always_comb begin
        w_entry  = {w_pushExt, w_pushBrk, i_rx_data};
        w_pop    = (r_count != '0) && i_ev_ready;
        w_full   = (r_count == DEPTH_C);
        w_accept = w_push && (!w_full || w_pop);
        w_drop   = w_push && w_full && !w_pop;
        w_rdNext = w_pop ? (r_rdPtr + PW'(1)) : r_rdPtr;
        w_countNext = r_count;
        if (w_accept && !w_pop) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_accept && w_pop) begin
            w_countNext = r_count - CW'(1);
        end
        // The next head may be the entry being written this very cycle
        // (push into an empty FIFO, or pop leaving only the new entry).
        if (w_accept && (w_rdNext == r_wrPtr)) begin
            w_headNext = w_entry;
        end else begin
            w_headNext = r_mem[w_rdNext];
        end
    end

    // Head register keeps the show-ahead outputs registered and lets them
    // hold their last value once the FIFO drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wrPtr] <= w_entry;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            r_rdPtr <= w_rdNext;
            r_count <= w_countNext;
            if (w_countNext != '0) begin
                r_head <= w_headNext;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_ev_valid   = (r_count != '0);
    assign o_ev_ext     = r_head[9];
    assign o_ev_break   = r_head[8];
    assign o_ev_code    = r_head[7:0];
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_err_pulse  = r_errPulse;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
// Directed bench for ps2_key_event_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge, the DUT acts on the rising edge.
module tb_ps2_key_event_ctrl;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int TO_W        = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxReady;
    logic [7:0] rxData;
    logic       evValid;
    logic       evReady;
    logic [7:0] evCode;
    logic       evExt;
    logic       evBreak;
    logic [2:0] fifoCount;
    logic       overflow;
    logic       errPulse;
    logic       clrOvf;

    int total = 0;
    int bad   = 0;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_ready  (rxReady),
        .i_rx_data   (rxData),
        .o_ev_valid  (evValid),
        .i_ev_ready  (evReady),
        .o_ev_code   (evCode),
        .o_ev_ext    (evExt),
        .o_ev_break  (evBreak),
        .o_fifo_count(fifoCount),
        .o_overflow  (overflow),
        .o_err_pulse (errPulse),
        .i_clr_ovf   (clrOvf)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Presents one byte for exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rxReady = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxReady = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic checkHead(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        checkOutput({tag, "_valid"}, {31'd0, evValid}, 32'd1);
        checkOutput({tag, "_code"}, {24'd0, evCode}, {24'd0, code});
        checkOutput({tag, "_ext"}, {31'd0, evExt}, {31'd0, ext});
        checkOutput({tag, "_brk"}, {31'd0, evBreak}, {31'd0, brk});
    endtask

    // Holds ev_ready high for one rising edge.
    task automatic popOne();
        evReady = 1'b1;
        @(negedge clk);
        evReady = 1'b0;
    endtask

    task automatic fillFour(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(base + 8'(i));
        end
    endtask

    initial begin
        logic [7:0] ovfCodes [4];
        int firstErr;

        reset   = 1'b1;
        rxReady = 1'b0;
        rxData  = 8'h00;
        evReady = 1'b0;
        clrOvf  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_valid", {31'd0, evValid}, 32'd0);
        checkOutput("rst_code", {24'd0, evCode}, 32'd0);
        checkOutput("rst_ext", {31'd0, evExt}, 32'd0);
        checkOutput("rst_brk", {31'd0, evBreak}, 32'd0);
        checkOutput("rst_count", {29'd0, fifoCount}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("rst_err", {31'd0, errPulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Make then break
        applyStimulus(8'h1C);
        checkHead("make", 8'h1C, 1'b0, 1'b0);
        checkOutput("make_count", {29'd0, fifoCount}, 32'd1);
        applyStimulus(8'hF0);
        checkOutput("f0_count", {29'd0, fifoCount}, 32'd1);
        applyStimulus(8'h1C);
        checkOutput("mb_count", {29'd0, fifoCount}, 32'd2);
        checkHead("mb_head0", 8'h1C, 1'b0, 1'b0);
        popOne();
        checkHead("mb_head1", 8'h1C, 1'b0, 1'b1);
        popOne();
        checkOutput("mb_empty", {31'd0, evValid}, 32'd0);
        checkOutput("mb_hold", {24'd0, evCode}, 32'h1C);

        // Extended make and break
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("ext_count", {29'd0, fifoCount}, 32'd2);
        checkHead("ext_head0", 8'h75, 1'b1, 1'b0);
        popOne();
        checkHead("ext_head1", 8'h75, 1'b1, 1'b1);
        popOne();
        checkOutput("ext_empty", {29'd0, fifoCount}, 32'd0);

        // Overflow: fifth event is lost
        ovfCodes[0] = 8'h15; ovfCodes[1] = 8'h1D; ovfCodes[2] = 8'h24; ovfCodes[3] = 8'h2D;
        for (int i = 0; i < 4; i++) applyStimulus(ovfCodes[i]);
        checkOutput("full_count", {29'd0, fifoCount}, 32'd4);
        checkOutput("full_noovf", {31'd0, overflow}, 32'd0);
        applyStimulus(8'h2C);
        checkOutput("ovf_count", {29'd0, fifoCount}, 32'd4);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkHead($sformatf("ovf_pop%0d", i), ovfCodes[i], 1'b0, 1'b0);
            popOne();
        end
        checkOutput("ovf_drained", {31'd0, evValid}, 32'd0);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
        clrOvf = 1'b1;
        @(negedge clk);
        clrOvf = 1'b0;
        checkOutput("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full with simultaneous push and pop
        fillFour(8'h11);
        checkOutput("fp_full", {29'd0, fifoCount}, 32'd4);
        rxReady = 1'b1;
        rxData  = 8'h4D;
        evReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        evReady = 1'b0;
        checkOutput("fp_count", {29'd0, fifoCount}, 32'd4);
        checkOutput("fp_noovf", {31'd0, overflow}, 32'd0);
        checkHead("fp_head0", 8'h12, 1'b0, 1'b0);
        popOne();
        checkHead("fp_head1", 8'h13, 1'b0, 1'b0);
        popOne();
        checkHead("fp_head2", 8'h14, 1'b0, 1'b0);
        popOne();
        checkHead("fp_head3", 8'h4D, 1'b0, 1'b0);
        popOne();
        checkOutput("fp_empty", {29'd0, fifoCount}, 32'd0);

        // Drop and clear in the same cycle: drop wins
        fillFour(8'h31);
        applyStimulus(8'h35);
        checkOutput("dc_ovf1", {31'd0, overflow}, 32'd1);
        rxReady = 1'b1;
        rxData  = 8'h36;
        clrOvf  = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        clrOvf  = 1'b0;
        checkOutput("dc_dropwins", {31'd0, overflow}, 32'd1);
        checkOutput("dc_count", {29'd0, fifoCount}, 32'd4);
        repeat (4) popOne();
        clrOvf = 1'b1;
        @(negedge clk);
        clrOvf = 1'b0;
        checkOutput("dc_clr", {31'd0, overflow}, 32'd0);

        // Timeout in a prefix state
        applyStimulus(8'hF0);
        checkOutput("to_noerr0", {31'd0, errPulse}, 32'd0);
        firstErr = -1;
        for (int k = 1; k <= TIMEOUT_CYC + 5; k++) begin
            @(negedge clk);
            if (errPulse && firstErr < 0) firstErr = k;
            if (firstErr >= 0) break;
        end
        checkOutput("to_cycle", firstErr, TIMEOUT_CYC);
        @(negedge clk);
        checkOutput("to_pulse1", {31'd0, errPulse}, 32'd0);
        checkOutput("to_nopush", {29'd0, fifoCount}, 32'd0);
        applyStimulus(8'h1C);
        checkHead("to_after", 8'h1C, 1'b0, 1'b0);
        popOne();

        // Error byte in GOT_E0
        applyStimulus(8'hE0);
        applyStimulus(8'hFF);
        checkOutput("err_pulse", {31'd0, errPulse}, 32'd1);
        checkOutput("err_noev", {29'd0, fifoCount}, 32'd0);
        @(negedge clk);
        checkOutput("err_pulse1", {31'd0, errPulse}, 32'd0);
        applyStimulus(8'h1C);
        checkHead("err_after", 8'h1C, 1'b0, 1'b0);
        popOne();

        // Reset in the middle of a sequence
        applyStimulus(8'h21);
        applyStimulus(8'h22);
        applyStimulus(8'hE0);
        checkOutput("mr_pre", {29'd0, fifoCount}, 32'd2);
        reset = 1'b1;
        #2;
        checkOutput("mr_valid", {31'd0, evValid}, 32'd0);
        checkOutput("mr_count", {29'd0, fifoCount}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(8'h1C);
        checkHead("mr_after", 8'h1C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
